timer_bank: RTL and testbench

//  Memory-mapped bank of NUM_TIMERS independent auto-reload up-counters on the CPU data bus.

---
 rtl/timer_bank.sv | 174 +++++++++++++++++
 tb/tb_timer_bank.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_TIMERS auto-reload up-counters.
// Each channel has its own block of four registers (TH, TL, TCON and PRESC),
// plus one shared IRQSTAT word after the last channel.
// rdata is zero outside the decoded window, so the bus mux can OR it in.
// Optional feature: define TIMER_PRESCALER_EN to build the per-channel 8-bit
// prescalers. Without it, PRESC reads 0 and channels tick every cycle.
module timer_bank #(
  parameter int          NUM_TIMERS = 2,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  localparam logic [31:0]      STAT_ADDR = BASE_ADDR + 32'(16 * NUM_TIMERS);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      th [NUM_TIMERS];
  logic [WIDTH-1:0]      tl [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] en;
  logic [NUM_TIMERS-1:0] ie;
  logic [NUM_TIMERS-1:0] pend;
  logic [NUM_TIMERS-1:0] oneshot;

  logic [NUM_TIMERS-1:0] sel_th;
  logic [NUM_TIMERS-1:0] sel_tl;
  logic [NUM_TIMERS-1:0] sel_tcon;
  logic                  sel_stat;
  logic [NUM_TIMERS-1:0] tick;
  logic [NUM_TIMERS-1:0] ovf;
  logic [NUM_TIMERS-1:0] pend_clr;

  // Address decode: every register needs an exact match on its word address.
  always_comb begin
    sel_stat = (addr == STAT_ADDR);
    for (int i = 0; i < NUM_TIMERS; i++) begin
      sel_th[i]   = (addr == BASE_ADDR + 32'(16 * i));
      sel_tl[i]   = (addr == BASE_ADDR + 32'(16 * i + 4));
      sel_tcon[i] = (addr == BASE_ADDR + 32'(16 * i + 8));
    end
  end

`ifdef TIMER_PRESCALER_EN
  logic [NUM_TIMERS-1:0] sel_presc;
  logic [7:0]            presc [NUM_TIMERS];
  logic [7:0]            pcnt  [NUM_TIMERS];

  // Decode the PRESC word and fire a tick when the prescale count reaches PRESC.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      sel_presc[i] = (addr == BASE_ADDR + 32'(16 * i + 12));
      tick[i]      = en[i] && (pcnt[i] == presc[i]);
    end
  end

  // Prescale counters are parked at 0 while disabled and restart on every PRESC write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        presc[i] <= 8'h00;
        pcnt[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr && sel_presc[i]) begin
          presc[i] <= wdata[7:0];
          pcnt[i]  <= 8'h00;
        end else if (!en[i] || (pcnt[i] == presc[i])) begin
          pcnt[i]  <= 8'h00;
        end else begin
          pcnt[i]  <= pcnt[i] + 8'h01;
        end
      end
    end
  end
`else
  // Without a prescaler, an enabled channel ticks on every cycle.
  always_comb begin
    tick = en;
  end
`endif

  // Overflow and pend-clear events. A TL write on the same edge cancels the
  // overflow completely: there is no reload and no pend.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      ovf[i]      = tick[i] && (tl[i] == '1) && !(wr && sel_tl[i]);
      pend_clr[i] = wr && ((sel_tcon[i] && wdata[2]) || (sel_stat && wdata[i]));
    end
  end

  // Channel state. Priority rules:
  //  - a bus write to TL beats a tick;
  //  - a reload uses the TH value from before the edge;
  //  - the overflow set beats a pend clear;
  //  - a TCON write beats the one-shot auto-disable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        th[i] <= '0;
        tl[i] <= '0;
      end
      en      <= '0;
      ie      <= '0;
      pend    <= '0;
      oneshot <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr && sel_th[i]) begin
          th[i] <= wdata[WIDTH-1:0];
        end

        if (wr && sel_tl[i]) begin
          tl[i] <= wdata[WIDTH-1:0];
        end else if (tick[i]) begin
          tl[i] <= (tl[i] == '1) ? th[i] : tl[i] + ONE;
        end

        if (wr && sel_tcon[i]) begin
          en[i]      <= wdata[0];
          ie[i]      <= wdata[1];
          oneshot[i] <= wdata[3];
        end else if (ovf[i] && oneshot[i]) begin
          en[i]      <= 1'b0;
        end

        if (ovf[i]) begin
          pend[i] <= 1'b1;
        end else if (pend_clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Read mux: zero-extended register value on a mapped hit while rd is high, otherwise 0.
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (sel_stat) begin
        rdata = 32'(pend);
      end
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (sel_th[i]) begin
          rdata = 32'(th[i]);
        end
        if (sel_tl[i]) begin
          rdata = 32'(tl[i]);
        end
        if (sel_tcon[i]) begin
          rdata = {28'h0, oneshot[i], pend[i], ie[i], en[i]};
        end
`ifdef TIMER_PRESCALER_EN
        if (sel_presc[i]) begin
          rdata = {24'h0, presc[i]};
        end
`endif
      end
    end
  end

  // Interrupt output: high while any channel has pend and ie both set.
  always_comb begin
    irqout = |(pend & ie);
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (NUM_TIMERS=2, WIDTH=32).
module tb_timer_bank;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] STAT = BASE + 32'(16 * N);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irqout;

  int tests = 0;
  int fails = 0;

  timer_bank #(.NUM_TIMERS(N), .WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irqout(irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] reg_addr(input int ch, input int off);
    return BASE + 32'(16 * ch + off);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d  = rdata;
    rd = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #3;
    tests++;
    if (irqout !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq: got %b expected 0", irqout);
    end
    for (int ch = 0; ch < N; ch++) begin
      for (int off = 0; off < 16; off += 4) begin
        bus_read(reg_addr(ch, off), d);
        tests++;
        if (d !== 32'h0) begin
          fails++;
          $display("FAIL reset_reg ch%0d+%0d: got %h expected 0", ch, off, d);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    bus_write(reg_addr(0, 0), 32'hFFFF_FFF0);
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFD);
    bus_write(reg_addr(0, 8), 32'h3);
    wait_cycles(2);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL ovf_pre_tl: got %h expected ffffffff", d);
    end
    tests++;
    if (irqout !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pre_irq: got %b expected 0", irqout);
    end
    wait_cycles(1);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'hFFFF_FFF0) begin
      fails++;
      $display("FAIL ovf_reload_tl: got %h expected fffffff0", d);
    end
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h7) begin
      fails++;
      $display("FAIL ovf_tcon: got %h expected 7", d);
    end
    tests++;
    if (irqout !== 1'b1) begin
      fails++;
      $display("FAIL ovf_irq: got %b expected 1", irqout);
    end
    wait_cycles(1);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'hFFFF_FFF1) begin
      fails++;
      $display("FAIL ovf_continue_tl: got %h expected fffffff1", d);
    end
    bus_write(reg_addr(0, 8), 32'h4);
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h0 || irqout !== 1'b0) begin
      fails++;
      $display("FAIL ovf_stop_clear: got tcon %h irq %b expected 0 0", d, irqout);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    bus_write(reg_addr(1, 0), 32'h5);
    bus_write(reg_addr(1, 4), 32'hFFFF_FFFF);
    bus_write(reg_addr(1, 8), 32'h9);
    wait_cycles(1);
    bus_read(reg_addr(1, 4), d);
    tests++;
    if (d !== 32'h5) begin
      fails++;
      $display("FAIL oneshot_tl: got %h expected 5", d);
    end
    bus_read(reg_addr(1, 8), d);
    tests++;
    if (d !== 32'hC) begin
      fails++;
      $display("FAIL oneshot_tcon: got %h expected c", d);
    end
    wait_cycles(3);
    bus_read(reg_addr(1, 4), d);
    tests++;
    if (d !== 32'h5 || irqout !== 1'b0) begin
      fails++;
      $display("FAIL oneshot_hold: got tl %h irq %b expected 5 0", d, irqout);
    end
    bus_read(STAT, d);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL oneshot_irqstat: got %h expected 2", d);
    end
    bus_write(reg_addr(1, 8), 32'h4);
    bus_read(STAT, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL tcon_w1c: got %h expected 0", d);
    end
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    bus_write(reg_addr(0, 0), 32'h0);
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFF);
    bus_write(reg_addr(0, 8), 32'h3);
    wait_cycles(1);
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h7) begin
      fails++;
      $display("FAIL race_first_pend: got %h expected 7", d);
    end
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFF);
    bus_write(STAT, 32'h1);
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h7 || irqout !== 1'b1) begin
      fails++;
      $display("FAIL race_set_wins: got tcon %h irq %b expected 7 1", d, irqout);
    end
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL race_reload_tl: got %h expected 0", d);
    end
    bus_write(STAT, 32'h1);
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h3 || irqout !== 1'b0) begin
      fails++;
      $display("FAIL race_later_clear: got tcon %h irq %b expected 3 0", d, irqout);
    end
  endtask

  task automatic test_bus;
    logic [31:0] d;
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFF);
    bus_write(reg_addr(0, 4), 32'h7);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'h7) begin
      fails++;
      $display("FAIL bus_tl_wins: got %h expected 7", d);
    end
    bus_read(reg_addr(0, 8), d);
    tests++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL bus_pend_unchanged: got %h expected 3", d);
    end
    bus_read(STAT + 32'h4, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL bus_unmapped: got %h expected 0", d);
    end
    addr = reg_addr(0, 8);
    rd   = 1'b0;
    #1;
    tests++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL bus_rd_low: got %h expected 0", rdata);
    end
    bus_write(reg_addr(0, 0), 32'h10);
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFF);
    bus_write(reg_addr(0, 0), 32'h20);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'h10) begin
      fails++;
      $display("FAIL bus_th_old_reload: got %h expected 10", d);
    end
    bus_read(reg_addr(0, 0), d);
    tests++;
    if (d !== 32'h20) begin
      fails++;
      $display("FAIL bus_th_new: got %h expected 20", d);
    end
    bus_write(reg_addr(0, 8), 32'h4);
    tests++;
    if (irqout !== 1'b0) begin
      fails++;
      $display("FAIL bus_final_irq: got %b expected 0", irqout);
    end
  endtask

  task automatic test_prescaler;
    logic [31:0] d;
    bus_write(reg_addr(1, 12), 32'hFFFF_FF03);
    bus_read(reg_addr(1, 12), d);
`ifdef TIMER_PRESCALER_EN
    tests++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL presc_read: got %h expected 3", d);
    end
`else
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL presc_read: got %h expected 0", d);
    end
`endif
    bus_write(reg_addr(1, 4), 32'h0);
    bus_write(reg_addr(1, 8), 32'h1);
`ifdef TIMER_PRESCALER_EN
    wait_cycles(4);
    bus_read(reg_addr(1, 4), d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL presc_tl4: got %h expected 1", d);
    end
    wait_cycles(4);
    bus_read(reg_addr(1, 4), d);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL presc_tl8: got %h expected 2", d);
    end
`else
    wait_cycles(8);
    bus_read(reg_addr(1, 4), d);
    tests++;
    if (d !== 32'h8) begin
      fails++;
      $display("FAIL presc_tl8: got %h expected 8", d);
    end
`endif
    bus_write(reg_addr(1, 8), 32'h0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(reg_addr(0, 0), 32'h55);
    bus_write(reg_addr(0, 4), 32'hFFFF_FFFF);
    bus_write(reg_addr(0, 8), 32'h3);
    wait_cycles(3);
    tests++;
    if (irqout !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre_irq: got %b expected 1", irqout);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (irqout !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_irq: got %b expected 0", irqout);
    end
    for (int ch = 0; ch < N; ch++) begin
      for (int off = 0; off < 16; off += 4) begin
        bus_read(reg_addr(ch, off), d);
        tests++;
        if (d !== 32'h0) begin
          fails++;
          $display("FAIL rstmid_reg ch%0d+%0d: got %h expected 0", ch, off, d);
        end
      end
    end
    bus_read(STAT, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_irqstat: got %h expected 0", d);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(3);
    bus_read(reg_addr(0, 4), d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_no_count: got %h expected 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_oneshot();
    test_w1c_race();
    test_bus();
    test_prescaler();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
